// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared state type, line geometry and line-base helper for the MEM-stage cache logic
package mips_mem_pkg;
    typedef enum logic [1:0] {IDLE, WB, REFILL, DONE} miss_state_t;
    localparam int DEF_WORDS_PER_LINE = 4;
    localparam int LINE_OFF_W = $clog2(DEF_WORDS_PER_LINE) + 2;
    function automatic logic [63:0] line_base(input logic [63:0] a, input int unsigned off_w);
        return a & ~((64'd1 << off_w) - 64'd1);
    endfunction
endpackage

// File: rtl/dcache_miss_ctrl_if.sv
// dcache_miss_ctrl_if: single-beat-per-word request/ack memory bus used for write-back and refill
interface dcache_miss_ctrl_if #(parameter int ADDR_W = 32);
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_ack;
    modport master (output bus_req, bus_we, bus_addr, input bus_ack);
    modport slave (input bus_req, bus_we, bus_addr, output bus_ack);
endinterface

// File: rtl/sat_counter.sv
// sat_counter: 16-bit saturating event counter with asynchronous active-low clear
module sat_counter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    output logic [15:0] cnt
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else if (inc && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
endmodule

// File: rtl/dcache_miss_ctrl.sv
// dcache_miss_ctrl: stalls the pipeline on a D-cache miss, writes back a dirty victim, refills the line
module dcache_miss_ctrl
    import mips_mem_pkg::*;
#(
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
    parameter int ADDR_W = 32
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              mem_access,
    input  logic                              cache_hit,
    input  logic                              line_dirty,
    input  logic [ADDR_W-1:0]                 miss_addr,
    input  logic [ADDR_W-1:0]                 victim_addr,
    output logic                              hit,
    output logic                              refill_we,
    output logic                              tag_we,
    output logic [$clog2(WORDS_PER_LINE)-1:0] word_idx,
    output logic [15:0]                       miss_cnt,
    dcache_miss_ctrl_if.master                bus
);
    localparam int BW = $clog2(WORDS_PER_LINE);
    localparam int OFF_W = BW + 2;
    miss_state_t state;
    logic [BW-1:0] beat;
    logic [ADDR_W-1:0] miss_base, victim_base;
    logic miss;
    assign miss = state == IDLE && mem_access && !cache_hit;
    // hit and refill_we are combinational; the rst_n term keeps them low throughout reset
    assign hit = rst_n && state == IDLE && !(mem_access && !cache_hit);
    assign refill_we = rst_n && state == REFILL && bus.bus_ack;
    assign word_idx = beat;
    assign bus.bus_addr = (state == WB ? victim_base : miss_base) + ADDR_W'({beat, 2'b00});
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            beat        <= '0;
            miss_base   <= '0;
            victim_base <= '0;
            bus.bus_req <= 1'b0;
            bus.bus_we  <= 1'b0;
            tag_we      <= 1'b0;
        end else begin
            tag_we <= 1'b0;
            case (state)
                IDLE: if (miss) begin
                    miss_base   <= ADDR_W'(line_base(64'(miss_addr), OFF_W));
                    victim_base <= ADDR_W'(line_base(64'(victim_addr), OFF_W));
                    beat        <= '0;
                    state       <= line_dirty ? WB : REFILL;
                    bus.bus_req <= 1'b1;
                    bus.bus_we  <= line_dirty;
                end
                WB: if (bus.bus_ack) begin
                    beat <= beat + BW'(1);
                    if (&beat) begin
                        state      <= REFILL;
                        bus.bus_we <= 1'b0;
                    end
                end
                REFILL: if (bus.bus_ack) begin
                    beat <= beat + BW'(1);
                    if (&beat) begin
                        state       <= DONE;
                        bus.bus_req <= 1'b0;
                        tag_we      <= 1'b1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
    sat_counter u_cnt (.clk(clk), .rst_n(rst_n), .inc(miss), .cnt(miss_cnt));
endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// tb_dcache_miss_ctrl: table-driven and randomized checks of the miss controller against a transaction model
module tb_dcache_miss_ctrl;
    localparam int W = 4;
    typedef struct {
        logic [31:0] ma;
        logic [31:0] va;
        logic        dirty;
        int          gap;
        int          stall;
    } vec_t;
    logic clk = 1'b0, rst_n = 1'b0, mem_access = 1'b0, cache_hit = 1'b0, line_dirty = 1'b0;
    logic [31:0] miss_addr = '0, victim_addr = '0;
    logic hit, refill_we, tag_we;
    logic [1:0] word_idx;
    logic [15:0] miss_cnt;
    int errors = 0, checks = 0, model_cnt = 0;
    dcache_miss_ctrl_if #(.ADDR_W(32)) bus ();
    dcache_miss_ctrl #(.WORDS_PER_LINE(W), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .mem_access(mem_access), .cache_hit(cache_hit),
        .line_dirty(line_dirty), .miss_addr(miss_addr), .victim_addr(victim_addr),
        .hit(hit), .refill_we(refill_we), .tag_we(tag_we), .word_idx(word_idx),
        .miss_cnt(miss_cnt), .bus(bus)
    );
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] base_of(input logic [31:0] a);
        return a - a % 32'(4 * W);
    endfunction

    task automatic scramble_mem_inputs();
        mem_access  = 1'($urandom);
        cache_hit   = 1'($urandom);
        line_dirty  = 1'($urandom);
        miss_addr   = $urandom;
        victim_addr = $urandom;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            mem_access = 1'($urandom);
            cache_hit  = 1'b1;
            line_dirty = 1'($urandom);
            miss_addr  = $urandom;
            bus.bus_ack = 1'($urandom);
            #1;
            chk("idle_hit", hit, 1);
            chk("idle_req", bus.bus_req, 0);
            chk("idle_tag_we", tag_we, 0);
            chk("idle_refill_we", refill_we, 0);
            chk("idle_cnt", miss_cnt, model_cnt);
        end
    endtask

    // gap > 0: ack on every gap-th request cycle; gap == 0: random 0..2 wait cycles per beat
    task automatic run_miss(input logic [31:0] ma, input logic [31:0] va, input logic dirty,
                            input int gap, input int abort_at, output int stall, output int exp_stall);
        logic [31:0] eaddr[$];
        logic ewe[$];
        int eidx[$];
        stall = 0;
        exp_stall = 2;
        for (int i = 0; i < W; i++)
            if (dirty) begin
                ewe.push_back(1'b1);
                eaddr.push_back(base_of(va) + 32'(4 * i));
                eidx.push_back(i);
            end
        for (int i = 0; i < W; i++) begin
            ewe.push_back(1'b0);
            eaddr.push_back(base_of(ma) + 32'(4 * i));
            eidx.push_back(i);
        end
        @(negedge clk);
        mem_access = 1'b1; cache_hit = 1'b0; line_dirty = dirty;
        miss_addr = ma; victim_addr = va; bus.bus_ack = 1'($urandom);
        #1;
        chk("detect_hit", hit, 0);
        chk("detect_req", bus.bus_req, 0);
        chk("detect_idx", word_idx, 0);
        stall += int'(!hit);
        if (model_cnt < 65535) model_cnt++;
        for (int b = 0; b < ewe.size(); b++) begin
            int w;
            w = gap <= 0 ? int'($urandom_range(0, 2)) : gap - 1;
            if (b == abort_at) return;
            exp_stall += w + 1;
            for (int j = 0; j <= w; j++) begin
                @(negedge clk);
                scramble_mem_inputs();
                bus.bus_ack = (j == w);
                #1;
                chk("beat_req", bus.bus_req, 1);
                chk("beat_we", bus.bus_we, ewe[b]);
                chk("beat_addr", bus.bus_addr, eaddr[b]);
                chk("beat_idx", word_idx, eidx[b]);
                chk("beat_refill_we", refill_we, (j == w) && !ewe[b]);
                chk("beat_hit", hit, 0);
                chk("beat_tag_we", tag_we, 0);
                stall += int'(!hit);
            end
        end
        @(negedge clk);
        scramble_mem_inputs();
        bus.bus_ack = 1'($urandom);
        #1;
        chk("done_tag_we", tag_we, 1);
        chk("done_req", bus.bus_req, 0);
        chk("done_hit", hit, 0);
        chk("done_refill_we", refill_we, 0);
        chk("done_cnt", miss_cnt, model_cnt);
        stall += int'(!hit);
    endtask

    initial begin
        vec_t vecs[5];
        int st, es;
        vecs[0] = '{32'h0000_1234, 32'h0000_0000, 1'b0, 1, 6};
        vecs[1] = '{32'h0000_1234, 32'h0000_8008, 1'b1, 1, 10};
        vecs[2] = '{32'h0000_1234, 32'h0000_0000, 1'b0, 3, 14};
        vecs[3] = '{32'hFFFF_FFFC, 32'h0000_0010, 1'b1, 2, 18};
        vecs[4] = '{32'h0000_000F, 32'hABCD_EF3F, 1'b1, 1, 10};
        bus.bus_ack = 1'b0;
        #1;
        chk("rst_hit", hit, 0);
        chk("rst_req", bus.bus_req, 0);
        chk("rst_we", bus.bus_we, 0);
        chk("rst_addr", bus.bus_addr, 0);
        chk("rst_idx", word_idx, 0);
        chk("rst_cnt", miss_cnt, 0);
        chk("rst_tag_we", tag_we, 0);
        chk("rst_refill_we", refill_we, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(10);
        for (int i = 0; i < 5; i++) begin
            run_miss(vecs[i].ma, vecs[i].va, vecs[i].dirty, vecs[i].gap, -1, st, es);
            chk("vec_stall", st, vecs[i].stall);
            idle_cycles(1);
        end
        run_miss(32'h0000_2040, 32'h0000_3000, 1'b0, 1, -1, st, es);
        run_miss(32'h0000_5558, 32'h0000_6664, 1'b1, 1, -1, st, es);
        chk("b2b_stall", st, 10);
        idle_cycles(1);
        run_miss(32'h0000_1234, 32'h0, 1'b0, 1, 2, st, es);
        @(negedge clk);
        rst_n = 1'b0; mem_access = 1'b0; bus.bus_ack = 1'b1;
        #1;
        chk("midrst_req", bus.bus_req, 0);
        chk("midrst_hit", hit, 0);
        chk("midrst_refill_we", refill_we, 0);
        chk("midrst_tag_we", tag_we, 0);
        chk("midrst_cnt", miss_cnt, 0);
        chk("midrst_idx", word_idx, 0);
        model_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1; mem_access = 1'b1; cache_hit = 1'b1; bus.bus_ack = 1'b0;
        #1;
        chk("post_rst_hit", hit, 1);
        chk("post_rst_idx", word_idx, 0);
        chk("post_rst_cnt", miss_cnt, 0);
        chk("post_rst_req", bus.bus_req, 0);
        run_miss(32'h4444_0010, 32'h0000_0020, 1'b1, 2, -1, st, es);
        chk("post_rst_stall", st, es);
        repeat (25) begin
            idle_cycles(int'($urandom_range(0, 2)));
            run_miss($urandom, $urandom, 1'($urandom), 0, -1, st, es);
            chk("rand_stall", st, es);
        end
        idle_cycles(1);
        @(negedge clk);
        mem_access = 1'b0;
        force dut.u_cnt.cnt = 16'hFFFD;
        @(negedge clk);
        release dut.u_cnt.cnt;
        model_cnt = 65533;
        #1;
        chk("preload_cnt", miss_cnt, 16'hFFFD);
        repeat (3) run_miss($urandom, $urandom, 1'($urandom), 1, -1, st, es);
        chk("sat_cnt", miss_cnt, 16'hFFFF);
        idle_cycles(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
